// File: rtl/dtree_feature_loader.sv
`default_nettype none
// ============================================================================
// Module      : dtree_feature_loader
// Description : Streams one feature frame per sample and captures five indexed
//               bytes for the tree classifier; flags short/long frames.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_feature_loader #(
    parameter int NUM_FEATURES = 279,
    parameter int IDX_A        = 13,
    parameter int IDX_B        = 27,
    parameter int IDX_C        = 235,
    parameter int IDX_D        = 264,
    parameter int IDX_E        = 278
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  X13,
    output logic [7:0]  X27,
    output logic [7:0]  X235,
    output logic [7:0]  X264,
    output logic [7:0]  X278,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [15:0] frame_cnt
);

    localparam logic [8:0] c_LAST_IDX = 9'(NUM_FEATURES - 1);
    localparam logic [8:0] c_IDX_A    = 9'(IDX_A);
    localparam logic [8:0] c_IDX_B    = 9'(IDX_B);
    localparam logic [8:0] c_IDX_C    = 9'(IDX_C);
    localparam logic [8:0] c_IDX_D    = 9'(IDX_D);
    localparam logic [8:0] c_IDX_E    = 9'(IDX_E);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_HOLD    = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_idx;
    logic [8:0]  w_idx_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_x_a;
    logic [7:0]  r_x_b;
    logic [7:0]  r_x_c;
    logic [7:0]  r_x_d;
    logic [7:0]  r_x_e;
    logic        w_xfer;
    logic        w_collect;
    logic        w_handoff;
    logic        w_is_last_idx;

    assign in_ready      = (r_state != S_HOLD);
    assign w_xfer        = in_valid & in_ready;
    assign w_collect     = w_xfer & (r_state == S_COLLECT);
    assign w_handoff     = (r_state == S_HOLD) & out_ready;
    assign w_is_last_idx = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_idx   <= 9'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (w_xfer) begin
                    if (in_last) begin
                        w_idx_nxt = 9'd0;
                        if (w_is_last_idx) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (w_is_last_idx) begin
                        // Frame overran its length: flag once, then swallow the tail.
                        w_err_nxt   = 1'b1;
                        w_idx_nxt   = 9'd0;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_idx_nxt = r_idx + 9'd1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DROP: begin
                if (w_xfer && in_last) begin
                    w_state_nxt = S_COLLECT;
                    w_idx_nxt   = 9'd0;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
                w_idx_nxt   = 9'd0;
            end
        endcase
    end

    // Feature registers are never cleared between frames, only overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_a <= 8'd0;
            r_x_b <= 8'd0;
            r_x_c <= 8'd0;
            r_x_d <= 8'd0;
            r_x_e <= 8'd0;
        end else if (w_collect) begin
            if (r_idx == c_IDX_A) r_x_a <= in_data;
            if (r_idx == c_IDX_B) r_x_b <= in_data;
            if (r_idx == c_IDX_C) r_x_c <= in_data;
            if (r_idx == c_IDX_D) r_x_d <= in_data;
            if (r_idx == c_IDX_E) r_x_e <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_handoff) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign X13       = r_x_a;
    assign X27       = r_x_b;
    assign X235      = r_x_c;
    assign X264      = r_x_d;
    assign X278      = r_x_e;
    assign out_valid = (r_state == S_HOLD);
    assign err       = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dtree_feature_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtree_feature_loader
// Description : Scoreboard bench for dtree_feature_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_feature_loader;

    localparam int NF = 279;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  X13, X27, X235, X264, X278;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] e;
    } feat_t;

    feat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    err_cnt  = 0;
    int    exp_cnt  = 0;
    int    e0;

    dtree_feature_loader #(
        .NUM_FEATURES(NF),
        .IDX_A       (13),
        .IDX_B       (27),
        .IDX_C       (235),
        .IDX_D       (264),
        .IDX_E       (278)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .X13      (X13),
        .X27      (X27),
        .X235     (X235),
        .X264     (X264),
        .X278     (X278),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return (mode == 0) ? kb : (8'd255 - kb);
    endfunction

    function automatic feat_t exp_of(input int mode);
        feat_t f;
        f.a = pat(mode, 13);
        f.b = pat(mode, 27);
        f.c = pat(mode, 235);
        f.d = pat(mode, 264);
        f.e = pat(mode, 278);
        return f;
    endfunction

    // Advance to the next falling edge; a handshake visible now completes at the
    // rising edge in between, so the scoreboard is popped before waiting.
    task automatic step();
        feat_t e;
        logic  hs;
        hs = out_valid && out_ready;
        if (hs) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("X13",  32'(X13),  32'(e.a));
                chk("X27",  32'(X27),  32'(e.b));
                chk("X235", 32'(X235), 32'(e.c));
                chk("X264", 32'(X264), 32'(e.d));
                chk("X278", 32'(X278), 32'(e.e));
                exp_cnt++;
            end
        end
        @(negedge clk);
        if (err) err_cnt++;
        if (hs) chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt & 16'hFFFF));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("rdy_timeout", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input bit gaps);
        for (int k = 0; k < NF; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) step();
            send_byte(pat(mode, k), k == NF - 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_x13",  32'(X13), 0);
        chk("rst_x278", 32'(X278), 0);
        chk("rst_ov",   32'(out_valid), 0);
        chk("rst_err",  32'(err), 0);
        chk("rst_cnt",  32'(frame_cnt), 0);
        chk("rst_rdy",  32'(in_ready), 1);

        // Good frame, immediate consumption
        exp_q.push_back(exp_of(0));
        send_frame(0, 1'b0);
        chk("t1_ov_lat", 32'(out_valid), 1);
        chk("t1_rdy_hold", 32'(in_ready), 0);
        step();
        chk("t1_rdy_after", 32'(in_ready), 1);
        chk("t1_cnt", 32'(frame_cnt), 1);

        // Back-pressure: hold for 10 cycles while offering a byte that must be ignored
        out_ready = 1'b0;
        exp_q.push_back(exp_of(0));
        send_frame(0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rdy",  32'(in_ready), 0);
            chk("bp_ov",   32'(out_valid), 1);
            chk("bp_x264", 32'(X264), 8);
            chk("bp_x278", 32'(X278), 22);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_rdy_after", 32'(in_ready), 1);
        chk("bp_ov_after",  32'(out_valid), 0);
        chk("bp_cnt",       32'(frame_cnt), 2);

        // Short frame ending on byte 100
        e0 = err_cnt;
        for (int k = 0; k <= 100; k++) send_byte(pat(0, k), k == 100);
        chk("short_err", 32'(err), 1);
        step();
        chk("short_err_pulse", 32'(err), 0);
        chk("short_ov", 32'(out_valid), 0);
        chk("short_errcnt", 32'(err_cnt - e0), 1);
        exp_q.push_back(exp_of(1));
        send_frame(1, 1'b0);
        chk("s_ov", 32'(out_valid), 1);
        chk("s_x13", 32'(X13), 242);
        chk("s_x278", 32'(X278), 233);
        step();

        // Long frame, 300 bytes
        e0 = err_cnt;
        for (int k = 0; k < 300; k++) begin
            send_byte(pat(0, k), k == 299);
            if (k == 277) chk("long_err_early", 32'(err), 0);
            if (k == 278) chk("long_err_at278", 32'(err), 1);
        end
        step();
        chk("long_errcnt", 32'(err_cnt - e0), 1);
        chk("long_ov", 32'(out_valid), 0);
        exp_q.push_back(exp_of(1));
        send_frame(1, 1'b0);
        chk("l_ov", 32'(out_valid), 1);
        step();

        // Good frame with random idle gaps
        exp_q.push_back(exp_of(0));
        send_frame(0, 1'b1);
        chk("gap_ov", 32'(out_valid), 1);
        step();

        // Reset mid-frame
        for (int k = 0; k < 150; k++) send_byte(pat(1, k), 1'b0);
        chk("pre_rst_x13", 32'(X13), 242);
        rst_n = 1'b0;
        #1;
        chk("arst_x13",  32'(X13), 0);
        chk("arst_x27",  32'(X27), 0);
        chk("arst_x235", 32'(X235), 0);
        chk("arst_cnt",  32'(frame_cnt), 0);
        chk("arst_ov",   32'(out_valid), 0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(exp_of(0));
        send_frame(0, 1'b0);
        chk("r_ov", 32'(out_valid), 1);
        step();
        chk("r_cnt", 32'(frame_cnt), 1);

        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("total_err", 32'(err_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtree_feature_loader.md
DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

Interface
REQ-001 Parameter NUM_FEATURES, default 279, number of feature bytes per sample frame (indices 0..NUM_FEATURES-1).
REQ-002 Parameters IDX_A/IDX_B/IDX_C/IDX_D/IDX_E, defaults 13/27/235/264/278, frame indices captured to outputs X13/X27/X235/X264/X278.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries a feature byte.
REQ-006 in_data  input  8  feature byte, unsigned.
REQ-007 in_last  input  1  marks final byte of a frame; qualified by in_valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 X13, X27, X235, X264, X278  output  8 each  captured features, fed directly to the tree classifier.
REQ-010 out_valid  output  1  captured feature set is complete and stable.
REQ-011 out_ready  input  1  downstream consumes the feature set.
REQ-012 err  output  1  one-cycle pulse on a malformed frame.
REQ-013 frame_cnt  output  16  count of good frames delivered; wraps at 65535 -> 0.

Function
REQ-014 Transfer occurs on a cycle with in_valid=1 and in_ready=1; no other cycle changes the byte index.
REQ-015 States: COLLECT, HOLD, DROP; reset state COLLECT.
REQ-016 in_ready = 1 in COLLECT and DROP, 0 in HOLD (combinational from state only, no dependency on in_valid).
REQ-017 Byte index idx (9 bits) = 0 at reset and at frame start; increments by 1 per accepted byte in COLLECT.
REQ-018 In COLLECT, an accepted byte with idx equal to IDX_n is written to the corresponding output register at that edge; other bytes are discarded.
REQ-019 COLLECT, accepted byte with in_last=1 and idx=NUM_FEATURES-1: go to HOLD, out_valid=1 from the next cycle, idx<=0.
REQ-020 COLLECT, accepted byte with in_last=1 and idx!=NUM_FEATURES-1 (short frame): err pulses next cycle, idx<=0, stay in COLLECT, out_valid stays 0.
REQ-021 COLLECT, accepted byte with in_last=0 and idx=NUM_FEATURES-1 (long frame): err pulses next cycle, go to DROP.
REQ-022 DROP: accept and discard bytes; on accepted in_last=1 go to COLLECT with idx=0; no further err pulses.
REQ-023 HOLD: X* outputs and out_valid held stable; on out_valid=1 and out_ready=1 go to COLLECT next cycle, out_valid<=0, frame_cnt increments by 1.
REQ-024 Outputs are not cleared between frames; a field not yet overwritten keeps its previous value while out_valid=0.
REQ-025 Latency: last byte accepted at edge N -> out_valid=1 during cycle N+1; after handoff at edge M, in_ready=1 during cycle M+1.
REQ-026 Partial-frame output values when out_valid=0 carry no meaning downstream.

Reset
REQ-027 rst_n=0 asynchronously forces: state COLLECT, idx 0, X13..X278 = 0, out_valid 0, err 0, frame_cnt 0; in_ready=1 once rst_n deasserted.
REQ-028 Reset asserted mid-frame or in HOLD discards the partial or pending frame; the first byte after release is index 0.

Verification
REQ-029 Good frame, byte k = k[7:0], in_valid always 1, out_ready=1 -> out_valid 1 cycle after last byte, X13=13, X27=27, X235=235, X264=8, X278=22, frame_cnt=1.
REQ-030 Back-pressure: out_ready=0 for 10 cycles after out_valid -> in_ready=0 and outputs stable for all 10 cycles; out_ready=1 -> handoff, in_ready=1 next cycle.
REQ-031 Short frame, in_last on byte 100 -> single err pulse, no out_valid; following good frame (byte k = 255-k[7:0]) -> X13=242, X278=233.
REQ-032 Long frame, 300 bytes with in_last on byte 299 -> err pulses once 1 cycle after byte 278; remaining bytes discarded; next good frame delivered correctly.
REQ-033 Random in_valid gaps (50% duty) on a good frame -> same outputs as REQ-029; idx unaffected by idle cycles.
REQ-034 rst_n pulsed low at byte 150 of a frame -> all outputs 0 immediately; a fresh full frame afterwards -> out_valid with correct values, frame_cnt=1.
